// File: rtl/ft_pkg.sv
// Shared types and constants for the FT601Q TX frame packer.
// Header word layout: MAGIC in [31:24], SOF flag in bit 23, block sequence in [15:0].
package ft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PAD     = 2'd2
  } state_e;

  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_SOF_BIT   = 23;
  localparam int HDR_SEQ_MSB   = 15;
  localparam int HDR_SEQ_LSB   = 0;

  localparam logic [7:0]  MAGIC_DEFAULT    = 8'hA5;
  localparam logic [31:0] PAD_WORD_DEFAULT = 32'h0000_0000;

  // Assemble a block header; bits [22:16] are reserved and stay zero.
  function automatic logic [31:0] make_header(input logic [7:0] magic,
                                              input logic sof,
                                              input logic [15:0] seq);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = magic;
    h[HDR_SOF_BIT] = sof;
    h[HDR_SEQ_MSB:HDR_SEQ_LSB] = seq;
    return h;
  endfunction

endpackage

// File: rtl/ft_byte_pack.sv
// Little-endian byte-to-word packer. Holds up to three bytes; the word is
// formed combinationally with the current byte so a full word (or a frame's
// final partial word, upper bytes zero) is presented in the accepting cycle.
module ft_byte_pack (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        accept_i,
  input  logic        last_i,
  input  logic [7:0]  data_i,
  input  logic        clr_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] hold_q, hold_d;

  // Word assembly and holding-register next state.
  always_comb begin
    word_valid_o = accept_i & ((byte_idx_q == 2'd3) | last_i);
    word_o       = {8'h00, hold_q} | ({24'h000000, data_i} << {byte_idx_q, 3'b000});
    hold_d       = hold_q;
    byte_idx_d   = byte_idx_q;
    if (clr_i || word_valid_o) begin
      // Clearing after each word keeps unused upper lanes zero for partial words.
      hold_d     = '0;
      byte_idx_d = '0;
    end else if (accept_i) begin
      hold_d     = word_o[23:0];
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  // Holding register and byte index.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      hold_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      hold_q     <= hold_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/ft_frame_packer.sv
// Frame packer for the FT601Q TX FIFO: byte stream in, fixed-size blocks of
// 32-bit words out (header + payload, padded to the block end after a frame).
// Handshakes: a byte moves when in_valid & in_ready; a word moves when wr_en,
// and wr_en is only raised while wr_full is low, so every write is taken once.
// Optional macro FT_FRAME_PACKER_TPG_EN adds a tpg input that turns the next
// block into a test-pattern block (payload counts up by 4, no bytes consumed).
module ft_frame_packer
  import ft_pkg::*;
#(
  parameter int          BLOCK_WORDS = 1024,
  parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT,
  parameter logic [31:0] PAD_WORD    = PAD_WORD_DEFAULT
) (
  input  logic        wr_clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  output logic [7:0]  frame_cnt,
  output logic [15:0] blk_cnt,
`ifdef FT_FRAME_PACKER_TPG_EN
  input  logic        tpg,
`endif
  output logic [1:0]  dbg_state_o
);

  localparam int IW = $clog2(BLOCK_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_WORDS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] word_idx_q, word_idx_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          sof_q, sof_d;
  logic          tpg_mode;
  logic          accept;
  logic          word_valid;
  logic [31:0]   word;
  logic          hdr_sof;

`ifdef FT_FRAME_PACKER_TPG_EN
  logic          tpg_mode_q, tpg_mode_d;
  logic [31:0]   tpg_cnt_q, tpg_cnt_d;
  assign tpg_mode = tpg_mode_q;
`else
  assign tpg_mode = 1'b0;
`endif

  // Bytes are only taken in a normal payload block with FIFO room.
  assign in_ready = nrst & (state_q == PAYLOAD) & ~tpg_mode & ~wr_full;
  assign accept   = in_valid & in_ready;

  assign frame_cnt   = frame_cnt_q;
  assign blk_cnt     = blk_cnt_q;
  assign dbg_state_o = state_q;

  ft_byte_pack u_pack (
    .clk_i        (wr_clk),
    .nrst_i       (nrst),
    .accept_i     (accept),
    .last_i       (in_last),
    .data_i       (in_data),
    .clr_i        (state_q != PAYLOAD),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state and write-port logic for the block sequencer.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    blk_cnt_d   = blk_cnt_q;
    frame_cnt_d = frame_cnt_q;
    sof_d       = sof_q;
    wr_en       = 1'b0;
    wr_data     = '0;
    hdr_sof     = sof_q;
`ifdef FT_FRAME_PACKER_TPG_EN
    tpg_mode_d  = tpg_mode_q;
    tpg_cnt_d   = tpg_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && !wr_full) begin
          sof_d = 1'b0;
`ifdef FT_FRAME_PACKER_TPG_EN
          tpg_mode_d = tpg;
          if (tpg) begin
            // Pattern blocks always flag SOF and leave the frame SOF pending.
            hdr_sof = 1'b1;
            sof_d   = sof_q;
          end
`endif
          wr_en      = 1'b1;
          wr_data    = make_header(MAGIC, hdr_sof, blk_cnt_q);
          blk_cnt_d  = blk_cnt_q + 16'd1;
          word_idx_d = IW'(1);
          state_d    = PAYLOAD;
        end
      end
      PAYLOAD: begin
`ifdef FT_FRAME_PACKER_TPG_EN
        if (tpg_mode_q) begin
          if (!wr_full) begin
            wr_en      = 1'b1;
            wr_data    = tpg_cnt_q;
            tpg_cnt_d  = tpg_cnt_q + 32'd4;
            word_idx_d = word_idx_q + IW'(1);
            if (word_idx_q == LAST_IDX) state_d = IDLE;
          end
        end else begin
`endif
        if (word_valid) begin
          wr_en      = 1'b1;
          wr_data    = word;
          word_idx_d = word_idx_q + IW'(1);
          if (in_last) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            sof_d       = 1'b1;
            state_d     = (word_idx_q == LAST_IDX) ? IDLE : PAD;
          end else if (word_idx_q == LAST_IDX) begin
            state_d = IDLE;
          end
        end
`ifdef FT_FRAME_PACKER_TPG_EN
        end
`endif
      end
      PAD: begin
        if (!wr_full) begin
          wr_en      = 1'b1;
          wr_data    = PAD_WORD;
          word_idx_d = word_idx_q + IW'(1);
          if (word_idx_q == LAST_IDX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // No writes leave the block while reset is held.
    if (!nrst) begin
      wr_en   = 1'b0;
      wr_data = '0;
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge wr_clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      word_idx_q  <= '0;
      blk_cnt_q   <= '0;
      frame_cnt_q <= '0;
      sof_q       <= 1'b1;
`ifdef FT_FRAME_PACKER_TPG_EN
      tpg_mode_q  <= 1'b0;
      tpg_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      blk_cnt_q   <= blk_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      sof_q       <= sof_d;
`ifdef FT_FRAME_PACKER_TPG_EN
      tpg_mode_q  <= tpg_mode_d;
      tpg_cnt_q   <= tpg_cnt_d;
`endif
    end
  end

endmodule

// File: doc/ft_frame_packer.md
Name: ft_frame_packer

Overview:
- Upstream stage of the FT601Q TX path. Converts a byte-wide frame stream, such as game video pixels, into 32-bit words on the FIFO write interface (wr_en/wr_data/wr_full).
- Output is organised into fixed blocks of BLOCK_WORDS words: one header word, then payload.
- A frame that ends mid-block is padded to a block boundary, so every host transfer meets the 4KB minimum transaction size.

Parameters:
- BLOCK_WORDS, 1024: words per block, header included. Power of two, >=4.
- MAGIC, 8'hA5: header marker byte.
- PAD_WORD, 32'h0000_0000: filler word after the end of a frame.

Ports:
- wr_clk  in  1  single clock; the FIFO write clock.
- nrst  in  1  synchronous active-low reset.
- en  in  1  packer enable; sampled only at block boundaries.
- in_valid  in  1  byte valid.
- in_data  in  8  payload byte.
- in_last  in  1  last byte of frame, qualified by in_valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- wr_en  out  1  FIFO write strobe.
- wr_data  out  32  FIFO write data.
- wr_full  in  1  FIFO full.
- frame_cnt  out  8  completed frames, wraps.
- blk_cnt  out  16  emitted blocks, wraps.

Behaviour:
- Single clock (wr_clk); reset synchronous, active-low (nrst).
- Reset values: in_ready=0, wr_en=0, wr_data=0, frame_cnt=0, blk_cnt=0, state=IDLE, byte_idx=0, word_idx=0, sof=1.
- Reset mid-operation: partial word and partial block are discarded. No padding is emitted.
- Write rule: wr_en is never asserted while wr_full=1. No write is ever dropped or duplicated.
- States and transitions:
  - IDLE: if en & ~wr_full, write the header and go to PAYLOAD.
    - Header = {MAGIC, sof, 7'b0, blk_cnt[15:0]}.
    - On the header write: blk_cnt increments, word_idx=1, sof clears.
  - PAYLOAD: in_ready = ~wr_full.
    - Bytes pack little-endian; the first byte lands in [7:0].
    - An accepted byte with byte_idx==3 writes the word in the same cycle (combinational from the 24-bit holding register plus the current byte). Byte-to-word latency is 0 cycles.
    - An accepted byte with in_last and byte_idx<3 writes the partial word with upper bytes zero.
    - byte_idx resets to 0 after every word write.
    - word_idx increments on each payload write.
  - Block full, no in_last (word_idx reaches BLOCK_WORDS-1 and wraps to 0): go to IDLE; the next header has sof=0.
  - in_last with the block not full: go to PAD; frame_cnt increments and sof sets.
  - in_last on the final word of a block: go to IDLE with no padding; frame_cnt increments and sof sets.
  - PAD: in_ready=0. Write PAD_WORD whenever ~wr_full until word_idx wraps, then go to IDLE.
- Widths: word_idx is $clog2(BLOCK_WORDS) bits with natural wrap. Counters wrap without saturation.
- in_valid while in IDLE or PAD is held off (in_ready=0). Its data is not consumed.
- en low only stops the block in IDLE; a block that has started always completes.

Optional Feature:
- Macro: FT_FRAME_PACKER_TPG_EN.
- Defined: adds input port tpg. When tpg=1 in IDLE, the next block is a test-pattern block.
  - in_ready=0 for the whole block.
  - Payload word = tpg_cnt, a 32-bit count starting at 0 and incrementing by 4 per payload word. It persists across blocks and is reset only by nrst.
  - Header sof=1, frame_cnt unchanged.
  - This matches the host low-byte +4 checker.
- Undefined: no tpg port and no tpg logic. Behaviour is exactly as above.

Decomposition:
- Package ft_pkg:
  - state enum (IDLE, PAYLOAD, PAD);
  - header field positions (MAGIC [31:24], SOF bit 23, seq [15:0]);
  - default MAGIC and PAD_WORD constants.
- Sub-module ft_byte_pack: byte_idx counter plus 24-bit holding register.
  - Inputs: byte accept, in_last, in_data, clr.
  - Outputs: word_valid and word, combinational.

Test Plan:
- Frame of 4092 bytes (1023 words), BLOCK_WORDS=1024, wr_full=0 -> exactly 1024 writes: header 32'hA580_0000, then payload; no PAD; frame_cnt=1, blk_cnt=1.
- Frame of 10 bytes 0x01..0x0A -> writes 32'hA580_0000, 32'h0403_0201, 32'h0807_0605, 32'h0000_0A09, then 1020 × PAD_WORD.
- Frame of 5000 bytes -> block0 header SOF=1, seq=0; block1 header 32'hA500_0001 with SOF=0; 2048 writes total.
- Toggle wr_full randomly at 50% during a 3-block frame -> wr_en & wr_full never both 1; data sequence identical to the wr_full=0 run.
- Assert nrst for 1 cycle mid-PAYLOAD after 7 bytes -> outputs return to reset values next cycle; next frame starts with header seq=0, SOF=1.
- With FT_FRAME_PACKER_TPG_EN and tpg=1 for 2 blocks -> payload words 0, 4, ..., 4088, then 4092, ...; in_ready stays 0.
